// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared widths, standard board divisors and the channel-index width helper.
package clkdiv_pkg;

    localparam int CNT_W_DEF = 32;

    localparam logic [CNT_W_DEF-1:0] VGA_DIV    = 32'd2;
    localparam logic [CNT_W_DEF-1:0] SEG_DIV    = 32'd100000;
    localparam logic [CNT_W_DEF-1:0] ONE_HZ_DIV = 32'd50000000;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider channel with active/shadow divisor, tick strobe and square output.
// With CLKDIV_TICK_CNT_EN defined it also counts emitted ticks.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(VGA_DIV),
    parameter int               TCNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sync,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_sq
`ifdef CLKDIV_TICK_CNT_EN
    ,
    output logic [TCNT_W-1:0] o_tick_cnt
`endif
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_shd;
    logic             r_pend;
    logic             r_tick;
    logic             r_sq;
    logic [CNT_W-1:0] w_div_eff;
    logic             w_term;

    assign w_div_eff = (r_div_act == '0) ? CNT_W'(1) : r_div_act;
    assign w_term    = i_en && (r_cnt == w_div_eff - CNT_W'(1));

    // Shadow only reaches the active divisor at a period boundary, sync or while stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_sq      <= 1'b0;
            r_div_act <= DIV_INIT;
            r_div_shd <= DIV_INIT;
            r_pend    <= 1'b0;
        end else begin
            if (i_wr) r_div_shd <= i_div;
            if (i_sync) begin
                r_cnt     <= '0;
                r_tick    <= 1'b0;
                r_sq      <= 1'b0;
                r_div_act <= i_wr ? i_div : (r_pend ? r_div_shd : r_div_act);
                r_pend    <= 1'b0;
            end else begin
                r_tick <= w_term;
                if (!i_en || w_term) begin
                    if (r_pend) r_div_act <= r_div_shd;
                    r_pend <= i_wr;
                end else begin
                    r_pend <= r_pend | i_wr;
                end
                if (w_term) begin
                    r_cnt <= '0;
                    r_sq  <= ~r_sq;
                end else if (i_en) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_tick = r_tick;
    assign o_sq   = r_sq;

    if (TCNT_W < 1) begin : g_bad_tcnt
        $error("clkdiv_channel: TCNT_W must be at least 1");
    end

`ifdef CLKDIV_TICK_CNT_EN
    logic [TCNT_W-1:0] r_tcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tcnt <= '0;
        else if (i_sync) r_tcnt <= '0;
        else if (w_term) r_tcnt <= r_tcnt + TCNT_W'(1);
    end

    assign o_tick_cnt = r_tcnt;
`endif

endmodule

// File: rtl/clock_enable_gen.sv
// clock_enable_gen: NUM_CH-channel clock-enable divider with run-time reloadable divisors.
// Define CLKDIV_TICK_CNT_EN to add per-channel tick counters on tick_cnt_o.
module clock_enable_gen
    import clkdiv_pkg::*;
#(
    parameter int                      NUM_CH   = 3,
    parameter int                      CNT_W    = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {ONE_HZ_DIV, SEG_DIV, VGA_DIV},
    parameter int                      TCNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sync_i,
    input  logic [NUM_CH-1:0]           ch_en_i,
    input  logic                        cfg_wr_i,
    input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch_i,
    input  logic [CNT_W-1:0]            cfg_div_i,
    output logic [NUM_CH-1:0]           tick_o,
    output logic [NUM_CH-1:0]           sq_o
`ifdef CLKDIV_TICK_CNT_EN
    ,
    output logic [NUM_CH*TCNT_W-1:0]    tick_cnt_o
`endif
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_wr;

        // Out-of-range channel addresses match no channel and are dropped.
        assign w_wr = cfg_wr_i && (32'(cfg_ch_i) == i);

        clkdiv_channel #(
            .CNT_W   (CNT_W),
            .DIV_INIT(DIV_INIT[i*CNT_W +: CNT_W]),
            .TCNT_W  (TCNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_sync    (sync_i),
            .i_en      (ch_en_i[i]),
            .i_wr      (w_wr),
            .i_div     (cfg_div_i),
            .o_tick    (tick_o[i]),
            .o_sq      (sq_o[i])
`ifdef CLKDIV_TICK_CNT_EN
            ,
            .o_tick_cnt(tick_cnt_o[i*TCNT_W +: TCNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// tb_clock_enable_gen: directed bench for clock_enable_gen with a default instance and a DIV=5/TCNT_W=4 instance.
module tb_clock_enable_gen;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        sync_i    = 1'b0;
    logic [2:0]  ch_en_i   = 3'b111;
    logic        cfg_wr_i  = 1'b0;
    logic [1:0]  cfg_ch_i  = 2'd0;
    logic [31:0] cfg_div_i = 32'd0;
    logic [2:0]  tick_a, sq_a, tick_b, sq_b;
`ifdef CLKDIV_TICK_CNT_EN
    logic [47:0] tcnt_a;
    logic [11:0] tcnt_b;
`endif
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clock_enable_gen u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_i    (sync_i),
        .ch_en_i   (ch_en_i),
        .cfg_wr_i  (cfg_wr_i),
        .cfg_ch_i  (cfg_ch_i),
        .cfg_div_i (cfg_div_i),
        .tick_o    (tick_a),
        .sq_o      (sq_a)
`ifdef CLKDIV_TICK_CNT_EN
        ,
        .tick_cnt_o(tcnt_a)
`endif
    );

    clock_enable_gen #(
        .DIV_INIT({32'd50000000, 32'd5, 32'd2}),
        .TCNT_W  (4)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_i    (sync_i),
        .ch_en_i   (ch_en_i),
        .cfg_wr_i  (cfg_wr_i),
        .cfg_ch_i  (cfg_ch_i),
        .cfg_div_i (cfg_div_i),
        .tick_o    (tick_b),
        .sq_o      (sq_b)
`ifdef CLKDIV_TICK_CNT_EN
        ,
        .tick_cnt_o(tcnt_b)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Channel 0 of instance A: tick expected on step first, first+period, ...
    task automatic run_ticks(input string tag, input int n, input int first, input int period);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            chk(tag, 64'(tick_a[0]), 64'((i >= first && (i - first) % period == 0) ? 1 : 0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        chk("rst_tick_a", 64'(tick_a), 64'(0));
        chk("rst_sq_a", 64'(sq_a), 64'(0));
        chk("rst_tick_b", 64'(tick_b), 64'(0));
        chk("rst_sq_b", 64'(sq_b), 64'(0));
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            chk("init_tick_a", 64'(tick_a), 64'({2'b00, (k % 2 == 0)}));
            chk("init_sq_a", 64'(sq_a), 64'({2'b00, 1'((k / 2) % 2)}));
            chk("init_tick_b", 64'(tick_b), 64'({1'b0, (k % 5 == 0), (k % 2 == 0)}));
            chk("init_sq_b", 64'(sq_b), 64'({1'b0, 1'((k / 5) % 2), 1'((k / 2) % 2)}));
        end
        cfg_wr_i  = 1'b1;
        cfg_ch_i  = 2'd0;
        cfg_div_i = 32'd3;
        run_ticks("wr3_cur", 1, 99, 1);
        cfg_wr_i = 1'b0;
        run_ticks("wr3_new", 7, 1, 3);
        cfg_wr_i  = 1'b1;
        cfg_div_i = 32'd7;
        run_ticks("wr7", 1, 99, 1);
        cfg_div_i = 32'd4;
        run_ticks("wr4", 1, 99, 1);
        cfg_wr_i = 1'b0;
        run_ticks("last_wins", 9, 1, 4);
        cfg_wr_i  = 1'b1;
        cfg_div_i = 32'd0;
        run_ticks("wr0", 1, 99, 1);
        cfg_wr_i = 1'b0;
        sync_i   = 1'b1;
        @(negedge clk);
        chk("sync_tick_a", 64'(tick_a), 64'(0));
        chk("sync_sq_a", 64'(sq_a), 64'(0));
        chk("sync_sq_b", 64'(sq_b), 64'(0));
        sync_i    = 1'b0;
        cfg_wr_i  = 1'b1;
        cfg_ch_i  = 2'd3;
        cfg_div_i = 32'd9;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("div0_tick", 64'(tick_a[0]), 64'(1));
            chk("div0_sq", 64'(sq_a[0]), 64'(i % 2));
        end
        cfg_ch_i  = 2'd0;
        cfg_div_i = 32'd5;
        sync_i    = 1'b1;
        @(negedge clk);
        chk("wrsync_tick", 64'(tick_a[0]), 64'(0));
        chk("wrsync_sq", 64'(sq_a[0]), 64'(0));
        cfg_wr_i = 1'b0;
        sync_i   = 1'b0;
        run_ticks("div5_pre", 7, 5, 5);
        ch_en_i = 3'b110;
        run_ticks("dis_tick", 10, 99, 1);
        chk("dis_sq_hold", 64'(sq_a[0]), 64'(1));
        ch_en_i = 3'b111;
        run_ticks("reen", 3, 3, 5);
        chk("reen_sq", 64'(sq_a[0]), 64'(0));
        run_ticks("pre_rst", 5, 5, 5);
        chk("pre_rst_sq", 64'(sq_a[0]), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tick_a", 64'(tick_a), 64'(0));
        chk("arst_sq_a", 64'(sq_a), 64'(0));
        chk("arst_tick_b", 64'(tick_b), 64'(0));
        chk("arst_sq_b", 64'(sq_b), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_ticks("post_rst", 4, 2, 2);
`ifdef CLKDIV_TICK_CNT_EN
        repeat (26) @(negedge clk);
        chk("tcnt_a_15", 64'(tcnt_a[15:0]), 64'(15));
        chk("tcnt_b_15", 64'(tcnt_b[3:0]), 64'(15));
        repeat (2) @(negedge clk);
        chk("tcnt_a_16", 64'(tcnt_a[15:0]), 64'(16));
        chk("tcnt_b_wrap", 64'(tcnt_b[3:0]), 64'(0));
        repeat (168) @(negedge clk);
        chk("tcnt_a_100", 64'(tcnt_a[15:0]), 64'(100));
        chk("tcnt_b_100", 64'(tcnt_b[3:0]), 64'(4));
        sync_i = 1'b1;
        @(negedge clk);
        sync_i = 1'b0;
        chk("tcnt_a_sync", 64'(tcnt_a[15:0]), 64'(0));
        chk("tcnt_b_sync", 64'(tcnt_b[3:0]), 64'(0));
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/clock_enable_gen.md
Name: clock_enable_gen

Overview:
- Parametrised multi-channel clock divider; successor to the fixed three-output divider.
- Produces, per channel, a registered one-cycle tick strobe (for use as a clock enable) and a 50%-duty square output.
- Each channel's divisor is set at elaboration time and reloadable at run time, applied glitch-free at the next terminal count.
- Sits at top level beside the board clock; feeds VGA, 7-segment scan and game-timer logic.

Parameters:
- NUM_CH, 3, number of independent channels
- CNT_W, 32, width of divisors and counters
- DIV_INIT, {32'd50000000, 32'd100000, 32'd2}, packed NUM_CH*CNT_W reset divisors; channel 0 in the LSBs
- TCNT_W, 16, width of the optional per-channel tick counters

Ports:
- clk  in  1  master clock (100 MHz board clock)
- rst_n  in  1  asynchronous active-low reset
- sync_i  in  1  synchronous phase-align pulse for all channels
- ch_en_i  in  NUM_CH  per-channel run enable
- cfg_wr_i  in  1  divisor write strobe
- cfg_ch_i  in  max(1,$clog2(NUM_CH))  channel addressed by the write
- cfg_div_i  in  CNT_W  new divisor value
- tick_o  out  NUM_CH  one-cycle strobe every DIV enabled cycles
- sq_o  out  NUM_CH  square output; toggles on each tick, period 2*DIV
- tick_cnt_o  out  NUM_CH*TCNT_W  only present with CLKDIV_TICK_CNT_EN

Behaviour:
- Reset (rst_n=0, asynchronous):
  - cnt=0, tick_o=0, sq_o=0.
  - Active and shadow divisors take DIV_INIT; pending flag cleared.
- Per channel, each cycle, in priority order:
  - sync_i=1: cnt<=0, sq<=0, tick<=0. Any pending divisor is applied immediately and pending is cleared.
  - ch_en=0: cnt and sq hold, tick<=0. Any pending divisor is applied immediately.
  - ch_en=1 and cnt==div_act-1: cnt<=0, tick<=1, sq<=~sq. Pending divisor becomes div_act and pending clears.
  - Otherwise: cnt<=cnt+1, tick<=0.
- Effective divisor: value 0 is treated as 1.
  - DIV=1 gives tick high every enabled cycle and sq toggling each cycle.
- Latency: after reset or sync, with enable held, the first tick is asserted in the register after the DIV-th enabled rising edge. Ticks then repeat exactly every DIV cycles.
- Config writes:
  - cfg_wr_i=1 with cfg_ch_i<NUM_CH loads the shadow register and sets pending.
  - A second write before the terminal count overwrites the shadow; last write wins.
  - cfg_ch_i>=NUM_CH is ignored.
- Write coinciding with a terminal count on the same channel:
  - The old pending value (if any) is applied this cycle.
  - The new value stays pending.
  - The current period is never truncated.
- Write coinciding with sync_i: the new value is applied immediately (write is captured first, then sync applies it).
- Counter never exceeds div_act-1. If div_act is lowered via sync while cnt is larger, sync zeroes cnt, so no wrap-around case exists.
- Re-enabling a channel resumes counting from the held cnt; the phase is preserved.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- CLKDIV_TICK_CNT_EN defined:
  - Each channel adds a TCNT_W-bit counter of emitted ticks, exposed on tick_cnt_o.
  - Counter resets to 0 on rst_n and on sync_i.
  - Wraps modulo 2^TCNT_W.
- Not defined: tick_cnt_o port and counters are absent; behaviour is otherwise identical.

Decomposition:
- clkdiv_pkg holds:
  - CNT_W_DEF=32.
  - Standard divisors: VGA_DIV=2 (25 MHz square), SEG_DIV=100000 (500 Hz), ONE_HZ_DIV=50000000 (1 Hz).
  - A helper function for channel-index width.
- Sub-module clkdiv_channel holds one channel's counter, active/shadow divisor, pending flag, tick/sq registers and the optional tick counter.
- The top level generate-loops clkdiv_channel NUM_CH times and decodes cfg writes.

Test Plan:
- Reset, DIV_INIT default, all enabled, 20 cycles:
  - ch0 tick every 2 cycles; sq0 period 4.
  - ch1/ch2 tick_o=0, sq=0.
- Override ch1 DIV_INIT=5, enabled 30 cycles:
  - ticks at enabled cycles 5,10,15…
  - sq1 toggles on each tick.
- Write ch0 div=3 mid-period at cnt=0 of a 2-cycle period:
  - The current period completes at 2.
  - Subsequent ticks are spaced 3 apart.
  - Two writes (7 then 4) before the terminal count give spacing 4.
- Divisor write cfg_div_i=0 then sync_i:
  - The channel ticks every cycle and sq toggles every cycle.
  - Write to cfg_ch_i=3 with NUM_CH=3 has no effect.
- Deassert ch_en for 10 cycles at cnt=2 of DIV=5:
  - tick=0 and cnt/sq hold.
  - Re-enable: next tick after 3 cycles.
- Assert rst_n=0 asynchronously mid-count: outputs go to 0 immediately. With CLKDIV_TICK_CNT_EN, check tick_cnt_o:
  - counts 100 ticks of ch0;
  - sync zeroes it;
  - TCNT_W=4 wraps 15→0.
